// File: rtl/swin_conditioner.sv
// rtl/swin_conditioner.sv - slide-switch synchroniser, per-bit debouncer and edge/sticky-change reporter
// Optional sticky change flag and mask are built only when SWIN_STICKY_EN is defined.
module swin_conditioner #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask,
    input  logic             ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sync1_d, sync2_d;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                // The DB_CYCLES-th consecutive disagreeing sample commits the new level.
                clean_d[i] = sync2_q[i];
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clean = clean_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

`ifdef SWIN_STICKY_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             changed_q, changed_d;

    // A pulse landing in the same cycle as ack survives the clear.
    always_comb begin
        mask_d    = (ack ? '0 : mask_q) | rise_q | fall_q;
        changed_d = |mask_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            changed_q <= changed_d;
        end
    end

    assign change_mask = mask_q;
    assign changed     = changed_q;
`else
    logic unused_ack;
    assign unused_ack  = ack;
    assign change_mask = '0;
    assign changed     = 1'b0;
`endif

endmodule

// File: tb/tb_swin_conditioner.sv
// tb/tb_swin_conditioner.sv - scoreboard bench for swin_conditioner (WIDTH=4, DB_CYCLES=4, CNT_W=3)
module tb_swin_conditioner;

    localparam int W  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = 4'hF;
    logic         ack = 1'b0;
    logic [W-1:0] sw_clean, rise, fall, change_mask;
    logic         changed;

    swin_conditioner #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean),
        .rise(rise), .fall(fall), .changed(changed),
        .change_mask(change_mask), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] mask;
        logic         chg;
        int           cyc;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: level seen by the debouncer is the raw value two edges old;
    // the clean level flips once DB consecutive samples disagree with it.
    logic [W-1:0] rawq[$];
    int           run [W];
    logic [W-1:0] m_clean, m_rise, m_fall, m_mask;
    logic [W-1:0] cur_raw;
    logic         cur_ack, cur_rst;

    task automatic model_reset();
        rawq    = {4'h0, 4'h0};
        m_clean = '0; m_rise = '0; m_fall = '0; m_mask = '0;
        for (int b = 0; b < W; b++) run[b] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] seen;
        logic [W-1:0] nr, nf;
        if (cur_rst) return;
        seen = rawq.pop_front();
        rawq.push_back(cur_raw);
        nr = '0; nf = '0;
        for (int b = 0; b < W; b++) begin
            if (seen[b] != m_clean[b]) begin
                run[b] = run[b] + 1;
                if (run[b] == DB) begin
                    if (seen[b]) nr[b] = 1'b1; else nf[b] = 1'b1;
                    m_clean[b] = seen[b];
                    run[b] = 0;
                end
            end else begin
                run[b] = 0;
            end
        end
        m_mask = (cur_ack ? 4'h0 : m_mask) | m_rise | m_fall;
        m_rise = nr;
        m_fall = nf;
    endtask

    task automatic step(input logic [W-1:0] raw, input logic a, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        if (r) model_reset();
        e.clean = m_clean;
        e.rise  = m_rise;
        e.fall  = m_fall;
`ifdef SWIN_STICKY_EN
        e.mask  = m_mask;
        e.chg   = |m_mask;
`else
        e.mask  = '0;
        e.chg   = 1'b0;
`endif
        e.cyc   = cyc;
        expq.push_back(e);
        sw_raw = raw; ack = a; reset = r;
        cur_raw = raw; cur_ack = a; cur_rst = r;
    endtask

    task automatic chk(input string name, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sw_clean",    e.cyc, sw_clean,    e.clean);
                chk("rise",        e.cyc, rise,        e.rise);
                chk("fall",        e.cyc, fall,        e.fall);
                chk("change_mask", e.cyc, change_mask, e.mask);
                chk("changed",     e.cyc, {3'b0, changed}, {3'b0, e.chg});
                chk("rise_fall_excl", e.cyc, rise & fall, 4'h0);
            end
        end
    end

    logic [W-1:0] r;

    initial begin : driver
        model_reset();
        cur_raw = 4'hF; cur_ack = 1'b0; cur_rst = 1'b1;
        // Switches held high through reset, then released.
        repeat (3) step(4'hF, 1'b0, 1'b1);
        repeat (10) step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        // Drop bit 0 then bit 2; ack in the cycle bit 2's pulse is visible.
        repeat (8) step(4'hE, 1'b0, 1'b0);
        step(4'hA, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !(m_rise[2] | m_fall[2]); k++) step(4'hA, 1'b0, 1'b0);
        step(4'hA, 1'b1, 1'b0);
        step(4'hA, 1'b1, 1'b0);
        repeat (3) step(4'hA, 1'b0, 1'b0);
        // Glitch on bit 1: high 3, low 1, high.
        repeat (3) step(4'hA, 1'b0, 1'b0);
        step(4'h8, 1'b0, 1'b0);
        repeat (8) step(4'hA, 1'b0, 1'b0);
        // Reset in the middle of a debounce.
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0);
        repeat (8) step(4'h0, 1'b0, 1'b0);
        // Random switching with bounce and random acks/resets.
        r = 4'h0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 399) == 0));
        end
        repeat (3) step(r, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", cyc, expq.size() > 1 ? 4'h1 : 4'h0, 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
